wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back stream and a long-latency multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO and keeps a 32-entry busy scoreboard for registers with an MDU result pending.
- Stalls decode on RAW/WAW against pending MDU results, and when buffered results are starved.
- Sits between the memory/write-back stage, the MDU and the register file.

Parameters:
- BUF_DEPTH, 2: MDU result FIFO entries. Must be ≥1.
- MAX_WAIT, 8: consecutive cycles a non-empty FIFO may lose arbitration before the starvation stall asserts. Must be ≥1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rstn_i  in  1  asynchronous active-low reset
- pipe_we_i  in  1  pipeline write request; cannot be back-pressured
- pipe_rd_i  in  5  pipeline destination register
- pipe_data_i  in  32  pipeline write data
- mdu_valid_i  in  1  MDU result valid
- mdu_rd_i  in  5  MDU destination register
- mdu_data_i  in  32  MDU result
- mdu_ready_o  out  1  FIFO can accept; equals rstn_i && (count < BUF_DEPTH)
- dec_valid_i  in  1  decode presents an instruction
- dec_mdu_i  in  1  decoded instruction is an MDU op
- dec_rs1_i  in  5  source 1
- dec_rs2_i  in  5  source 2
- dec_rd_i  in  5  destination
- stall_o  out  1  combinational decode stall
- busy_o  out  32  scoreboard bits; bit 0 always 0
- rf_we_o  out  1  registered register-file write enable
- rf_waddr_o  out  5  registered write address
- rf_wdata_o  out  32  registered write data
- fifo_count_o  out  $clog2(BUF_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rstn_i low, async):
  - rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0.
  - FIFO empty, fifo_count_o = 0, busy_o = 0, wait counter 0, starve flag 0.
  - mdu_ready_o = 0 while in reset.
  - Reset mid-operation discards all buffered results and busy bits.
- Pipe request: active when pipe_we_i && pipe_rd_i != 0. pipe_rd_i == 0 is treated as idle.
- Arbitration, evaluated each edge:
  - Active pipe request wins: rf_* = pipe values on the next edge. Latency 1.
  - Otherwise, if the FIFO is non-empty, pop the head into rf_*.
  - Otherwise, rf_we_o = 0. rf_waddr_o and rf_wdata_o hold their last values.
  - rf_* remain stable for the whole cycle, so the register file may sample on the falling edge.
- MDU accept: mdu_valid_i && mdu_ready_o at an edge.
  - If mdu_rd_i == 0, the result is accepted and dropped (not stored).
  - Otherwise it is pushed to the FIFO tail.
  - Push and pop on the same edge are both legal when full: the pop frees a slot only after that edge, so mdu_ready_o reflects pre-edge count.
  - Minimum MDU latency without bypass: accept at edge N, rf_we_o high after edge N+1.
- Scoreboard:
  - Set busy[dec_rd_i] when dec_valid_i && dec_mdu_i && !stall_o && dec_rd_i != 0.
  - Clear busy[rd] when an FIFO entry with that rd is popped to rf_*.
  - Set and clear of the same bit on one edge: set wins.
- stall_o = dec_valid_i && (busy[dec_rs1_i] || busy[dec_rs2_i] || busy[dec_rd_i] || starve).
  - Because busy[dec_rd_i] stalls, WAW to a pending register is prevented, so at most one FIFO entry per rd exists.
- Starvation:
  - Wait counter increments on each edge where the FIFO is non-empty and the pipe wins.
  - It saturates at MAX_WAIT and clears on any pop or when the FIFO is empty.
  - starve = (counter == MAX_WAIT). It stays asserted until the next pop.
- fifo_count_o is updated on the edge: +1 push, −1 pop, unchanged for both or neither.

Optional Feature:
- WB_BYPASS_EN, defined:
  - When the FIFO is empty, there is no active pipe request, and an MDU result with rd != 0 is accepted, the result is written straight to rf_* on the same edge. Latency 1.
  - The busy bit for that rd clears on that same edge, and the FIFO is not touched.
- WB_BYPASS_EN, undefined: all MDU results pass through the FIFO (minimum latency 2).

Test Plan:
1. Reset-in-flight: after reset, pipe_we_i=1 rd=5 data=0xDEADBEEF for 1 cycle → next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF. Then rf_we_o=0. Assert rstn_i low mid-burst → all outputs 0 immediately (async).
2. Contention: MDU result rd=7 data=0x12 accepted while pipe writes rd=3 and rd=4 on consecutive cycles → rd=3, then rd=4, then rd=7/0x12 on rf_*. busy_o[7] 1→0 on the pop edge.
3. Full FIFO: BUF_DEPTH=2, pipe busy continuously, three MDU results offered → mdu_ready_o=0 after two accepts, fifo_count_o=2. Third result held by the MDU until a pop.
4. Scoreboard stall: issue MDU op rd=9; next decode with rs1=9 → stall_o=1 until the rd=9 pop, then 0. Decode with rd=0 never sets busy; mdu_rd_i=0 is dropped with no write.
5. Starvation: MAX_WAIT=8, one buffered entry, pipe writes 8 consecutive cycles → stall_o=1 from the 9th cycle with dec_valid_i=1. Clears after the pop once the pipe goes idle.
6. WB_BYPASS_EN: empty FIFO, pipe idle, MDU rd=2 data=0x55 → rf_we_o=1 the next cycle and fifo_count_o stays 0. Without the macro, the write appears one cycle later.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bus bundle between the write-back arbiter and its neighbours
//   (pipeline write-back, MDU, decode, register file).
//   Signal names are kept identical to the original flat port list.
//   Parameter BUF_DEPTH sizes fifo_count_o and must match the arbiter.
//   Modports:
//     slave  - the arbiter side (consumes requests, drives rf_*, stall, status)
//     master - the environment side (drives requests, observes outputs)
interface wb_port_arbiter_if #(
  parameter int unsigned BUF_DEPTH = 2
);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic          pipe_we_i;
  logic [4:0]    pipe_rd_i;
  logic [31:0]   pipe_data_i;
  logic          mdu_valid_i;
  logic [4:0]    mdu_rd_i;
  logic [31:0]   mdu_data_i;
  logic          mdu_ready_o;
  logic          dec_valid_i;
  logic          dec_mdu_i;
  logic [4:0]    dec_rs1_i;
  logic [4:0]    dec_rs2_i;
  logic [4:0]    dec_rd_i;
  logic          stall_o;
  logic [31:0]   busy_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [31:0]   rf_wdata_o;
  logic [CW-1:0] fifo_count_o;

  modport slave (
    input  pipe_we_i, pipe_rd_i, pipe_data_i,
    input  mdu_valid_i, mdu_rd_i, mdu_data_i,
    output mdu_ready_o,
    input  dec_valid_i, dec_mdu_i, dec_rs1_i, dec_rs2_i, dec_rd_i,
    output stall_o, busy_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, fifo_count_o
  );

  modport master (
    output pipe_we_i, pipe_rd_i, pipe_data_i,
    output mdu_valid_i, mdu_rd_i, mdu_data_i,
    input  mdu_ready_o,
    output dec_valid_i, dec_mdu_i, dec_rs1_i, dec_rs2_i, dec_rd_i,
    input  stall_o, busy_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, fifo_count_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order
//   pipeline write-back stream and the multiply/divide unit (MDU).
//   MDU results are buffered in a BUF_DEPTH-entry FIFO; a 32-bit busy
//   scoreboard tracks registers with an MDU result still pending and
//   decode is stalled on RAW/WAW hazards against them, or when buffered
//   results have lost arbitration MAX_WAIT times in a row.
//   Ports:
//     clk_i   - clock, rising edge
//     rstn_i  - asynchronous active-low reset
//     bus     - wb_port_arbiter_if.slave (pipe/MDU/decode inputs,
//               rf_* write port, stall_o, busy_o, mdu_ready_o, fifo_count_o)
//   Build option:
//     WB_BYPASS_EN - when defined, an MDU result arriving with the FIFO
//                    empty and the pipeline idle is written directly.
module wb_port_arbiter #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned MAX_WAIT  = 8
) (
  input logic              clk_i,
  input logic              rstn_i,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [4:0]    fifo_rd   [BUF_DEPTH];
  logic [31:0]   fifo_data [BUF_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [WW-1:0] wait_q;
  logic [31:0]   busy_q, busy_d;
  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;

  logic          pipe_act, mdu_ready, accept, fifo_empty;
  logic          pop, push, bypass, starve, stall, issue;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pipe_act   = bus.pipe_we_i && (bus.pipe_rd_i != '0);
    mdu_ready  = rstn_i && (count_q < FULL_CNT);
    accept     = bus.mdu_valid_i && mdu_ready;
    fifo_empty = (count_q == '0);
    pop        = !pipe_act && !fifo_empty;
`ifdef WB_BYPASS_EN
    bypass     = accept && (bus.mdu_rd_i != '0) && fifo_empty && !pipe_act;
`else
    bypass     = 1'b0;
`endif
    // rd==0 results are accepted and dropped; bypassed results skip the FIFO.
    push       = accept && (bus.mdu_rd_i != '0) && !bypass;
    starve     = (wait_q == WAIT_MAX);
    stall      = bus.dec_valid_i && (busy_q[bus.dec_rs1_i] || busy_q[bus.dec_rs2_i] ||
                                     busy_q[bus.dec_rd_i] || starve);
    issue      = bus.dec_valid_i && bus.dec_mdu_i && !stall && (bus.dec_rd_i != '0);
    head_rd    = fifo_rd[head_q];
    head_data  = fifo_data[head_q];
  end

  // Clears are applied before the set so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop)    busy_d[head_rd]      = 1'b0;
    if (bypass) busy_d[bus.mdu_rd_i] = 1'b0;
    if (issue)  busy_d[bus.dec_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q <= busy_d;

      if (pipe_act) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.pipe_rd_i;
        rf_wdata_q <= bus.pipe_data_i;
      end else if (pop) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= head_rd;
        rf_wdata_q <= head_data;
      end else if (bypass) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.mdu_rd_i;
        rf_wdata_q <= bus.mdu_data_i;
      end else begin
        rf_we_q    <= 1'b0;
      end

      if (push) tail_q <= ptr_next(tail_q);
      if (pop)  head_q <= ptr_next(head_q);

      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);

      // A non-empty FIFO that is not popped means the pipe won this edge.
      if (pop || fifo_empty)    wait_q <= '0;
      else if (wait_q != WAIT_MAX) wait_q <= wait_q + WW'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd[tail_q]   <= bus.mdu_rd_i;
      fifo_data[tail_q] <= bus.mdu_data_i;
    end
  end

  assign bus.mdu_ready_o  = mdu_ready;
  assign bus.stall_o      = stall;
  assign bus.busy_o       = busy_q;
  assign bus.rf_we_o      = rf_we_q;
  assign bus.rf_waddr_o   = rf_waddr_q;
  assign bus.rf_wdata_o   = rf_wdata_q;
  assign bus.fifo_count_o = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  wb_port_arbiter_if #(.BUF_DEPTH(2)) bus ();

  wb_port_arbiter #(.BUF_DEPTH(2), .MAX_WAIT(8)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pwe;  logic [4:0] prd;  logic [31:0] pdata;
    logic        mv;   logic [4:0] mrd;  logic [31:0] mdata;
    logic        dv;   logic       dmdu;
    logic [4:0]  rs1;  logic [4:0] rs2;  logic [4:0]  drd;
    logic        stall; logic      ready;
    logic        we;   logic [4:0] waddr; logic [31:0] wdata;
    logic [1:0]  cnt;  logic [31:0] busy;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [1:0] cnt, input logic [31:0] busy);
    check({tag, " rf_we"},    32'(bus.rf_we_o),      32'(we));
    check({tag, " rf_waddr"}, 32'(bus.rf_waddr_o),   32'(wa));
    check({tag, " rf_wdata"}, bus.rf_wdata_o,        wd);
    check({tag, " count"},    32'(bus.fifo_count_o), 32'(cnt));
    check({tag, " busy"},     bus.busy_o,            busy);
  endtask

  // Called at a negedge: drive, check combinational outputs, clock, check state.
  task automatic apply(input vec_t v, input string tag);
    bus.pipe_we_i   = v.pwe;  bus.pipe_rd_i = v.prd;  bus.pipe_data_i = v.pdata;
    bus.mdu_valid_i = v.mv;   bus.mdu_rd_i  = v.mrd;  bus.mdu_data_i  = v.mdata;
    bus.dec_valid_i = v.dv;   bus.dec_mdu_i = v.dmdu;
    bus.dec_rs1_i   = v.rs1;  bus.dec_rs2_i = v.rs2;  bus.dec_rd_i    = v.drd;
    #1;
    check({tag, " stall"},     32'(bus.stall_o),     32'(v.stall));
    check({tag, " mdu_ready"}, 32'(bus.mdu_ready_o), 32'(v.ready));
    @(posedge clk); #1;
    check_regs(tag, v.we, v.waddr, v.wdata, v.cnt, v.busy);
    @(negedge clk);
  endtask

  function automatic vec_t idle(input logic st, input logic rdy, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [1:0] cnt, input logic [31:0] busy);
    vec_t v;
    v = '{L, 5'd0, 32'h0, L, 5'd0, 32'h0, L, L, 5'd0, 5'd0, 5'd0,
          st, rdy, we, wa, wd, cnt, busy};
    return v;
  endfunction

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;

    // pwe prd pdata | mv mrd mdata | dv dmdu rs1 rs2 drd || stall ready we waddr wdata cnt busy
    vecs[0]  = '{H, 5'd5, 32'hDEADBEEF, L, 5'd0, 32'h0,  L, L, 5'd0, 5'd0, 5'd0,
                 L, H, H, 5'd5, 32'hDEADBEEF, 2'd0, 32'h0};
    vecs[1]  = idle(L, H, L, 5'd5, 32'hDEADBEEF, 2'd0, 32'h0);
    vecs[2]  = '{L, 5'd0, 32'h0, L, 5'd0, 32'h0,  H, H, 5'd0, 5'd0, 5'd7,
                 L, H, L, 5'd5, 32'hDEADBEEF, 2'd0, 32'h80};
    vecs[3]  = '{H, 5'd3, 32'h33, H, 5'd7, 32'h12,  L, L, 5'd0, 5'd0, 5'd0,
                 L, H, H, 5'd3, 32'h33, 2'd1, 32'h80};
    vecs[4]  = '{H, 5'd4, 32'h44, L, 5'd0, 32'h0,  L, L, 5'd0, 5'd0, 5'd0,
                 L, H, H, 5'd4, 32'h44, 2'd1, 32'h80};
    vecs[5]  = idle(L, H, H, 5'd7, 32'h12, 2'd0, 32'h0);
    vecs[6]  = '{L, 5'd0, 32'h0, L, 5'd0, 32'h0,  H, H, 5'd0, 5'd0, 5'd9,
                 L, H, L, 5'd7, 32'h12, 2'd0, 32'h200};
    vecs[7]  = '{L, 5'd0, 32'h0, L, 5'd0, 32'h0,  H, L, 5'd9, 5'd0, 5'd10,
                 H, H, L, 5'd7, 32'h12, 2'd0, 32'h200};
`ifdef WB_BYPASS_EN
    vecs[8]  = '{L, 5'd0, 32'h0, H, 5'd9, 32'h99,  H, L, 5'd9, 5'd0, 5'd10,
                 H, H, H, 5'd9, 32'h99, 2'd0, 32'h0};
    vecs[9]  = '{L, 5'd0, 32'h0, L, 5'd0, 32'h0,  H, L, 5'd9, 5'd0, 5'd10,
                 L, H, L, 5'd9, 32'h99, 2'd0, 32'h0};
`else
    vecs[8]  = '{L, 5'd0, 32'h0, H, 5'd9, 32'h99,  H, L, 5'd9, 5'd0, 5'd10,
                 H, H, L, 5'd7, 32'h12, 2'd1, 32'h200};
    vecs[9]  = '{L, 5'd0, 32'h0, L, 5'd0, 32'h0,  H, L, 5'd9, 5'd0, 5'd10,
                 H, H, H, 5'd9, 32'h99, 2'd0, 32'h0};
`endif
    vecs[10] = '{L, 5'd0, 32'h0, L, 5'd0, 32'h0,  H, L, 5'd9, 5'd0, 5'd10,
                 L, H, L, 5'd9, 32'h99, 2'd0, 32'h0};
    vecs[11] = '{L, 5'd0, 32'h0, L, 5'd0, 32'h0,  H, H, 5'd0, 5'd0, 5'd0,
                 L, H, L, 5'd9, 32'h99, 2'd0, 32'h0};
    vecs[12] = '{L, 5'd0, 32'h0, H, 5'd0, 32'hAA,  L, L, 5'd0, 5'd0, 5'd0,
                 L, H, L, 5'd9, 32'h99, 2'd0, 32'h0};

    // Reset
    rstn = 1'b0;
    v = idle(L, L, L, 5'd0, 32'h0, 2'd0, 32'h0);
    bus.pipe_we_i = L; bus.pipe_rd_i = '0; bus.pipe_data_i = '0;
    bus.mdu_valid_i = H; bus.mdu_rd_i = 5'd1; bus.mdu_data_i = '0;
    bus.dec_valid_i = L; bus.dec_mdu_i = L;
    bus.dec_rs1_i = '0; bus.dec_rs2_i = '0; bus.dec_rd_i = '0;
    @(posedge clk); #1;
    check("reset mdu_ready", 32'(bus.mdu_ready_o), 32'(L));
    check_regs("reset", L, 5'd0, 32'h0, 2'd0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Full FIFO: pipe busy, three MDU results offered; third waits for a pop
    apply('{H, 5'd1, 32'h1, H, 5'd11, 32'hB1, L, L, 5'd0, 5'd0, 5'd0,
            L, H, H, 5'd1, 32'h1, 2'd1, 32'h0}, "full1");
    apply('{H, 5'd1, 32'h2, H, 5'd12, 32'hB2, L, L, 5'd0, 5'd0, 5'd0,
            L, H, H, 5'd1, 32'h2, 2'd2, 32'h0}, "full2");
    apply('{H, 5'd1, 32'h3, H, 5'd13, 32'hB3, L, L, 5'd0, 5'd0, 5'd0,
            L, L, H, 5'd1, 32'h3, 2'd2, 32'h0}, "full3");
    apply('{L, 5'd0, 32'h0, H, 5'd13, 32'hB3, L, L, 5'd0, 5'd0, 5'd0,
            L, L, H, 5'd11, 32'hB1, 2'd1, 32'h0}, "full4");
    apply('{L, 5'd0, 32'h0, H, 5'd13, 32'hB3, L, L, 5'd0, 5'd0, 5'd0,
            L, H, H, 5'd12, 32'hB2, 2'd1, 32'h0}, "full5");
    apply(idle(L, H, H, 5'd13, 32'hB3, 2'd0, 32'h0), "full6");
    apply(idle(L, H, L, 5'd13, 32'hB3, 2'd0, 32'h0), "full7");

    // Starvation: one buffered entry, pipe keeps winning
    apply('{H, 5'd1, 32'h100, H, 5'd14, 32'hC0, H, L, 5'd1, 5'd1, 5'd1,
            L, H, H, 5'd1, 32'h100, 2'd1, 32'h0}, "starve0");
    for (int k = 1; k <= 9; k++) begin
      v = '{H, 5'd1, 32'h100 + 32'(k), L, 5'd0, 32'h0, H, L, 5'd1, 5'd1, 5'd1,
            (k >= 9) ? H : L, H, H, 5'd1, 32'h100 + 32'(k), 2'd1, 32'h0};
      apply(v, $sformatf("starve%0d", k));
      check($sformatf("starve%0d post stall", k), 32'(bus.stall_o), (k >= 8) ? 32'd1 : 32'd0);
    end
    apply('{L, 5'd0, 32'h0, L, 5'd0, 32'h0, H, L, 5'd1, 5'd1, 5'd1,
            H, H, H, 5'd14, 32'hC0, 2'd0, 32'h0}, "starve_pop");
    check("starve cleared stall", 32'(bus.stall_o), 32'd0);

    // Minimum MDU latency, with the scoreboard bit cleared on the write
    apply('{L, 5'd0, 32'h0, L, 5'd0, 32'h0, H, H, 5'd0, 5'd0, 5'd2,
            L, H, L, 5'd14, 32'hC0, 2'd0, 32'h4}, "lat_issue");
`ifdef WB_BYPASS_EN
    apply('{L, 5'd0, 32'h0, H, 5'd2, 32'h55, L, L, 5'd0, 5'd0, 5'd0,
            L, H, H, 5'd2, 32'h55, 2'd0, 32'h0}, "lat_accept");
    apply(idle(L, H, L, 5'd2, 32'h55, 2'd0, 32'h0), "lat_after");
`else
    apply('{L, 5'd0, 32'h0, H, 5'd2, 32'h55, L, L, 5'd0, 5'd0, 5'd0,
            L, H, L, 5'd14, 32'hC0, 2'd1, 32'h4}, "lat_accept");
    apply(idle(L, H, H, 5'd2, 32'h55, 2'd0, 32'h0), "lat_after");
`endif

    // Asynchronous reset with a buffered result and a busy bit pending
    apply('{L, 5'd0, 32'h0, L, 5'd0, 32'h0, H, H, 5'd0, 5'd0, 5'd20,
            L, H, L, 5'd2, 32'h55, 2'd0, 32'h0010_0000}, "rst_issue");
    apply('{H, 5'd6, 32'h66, H, 5'd20, 32'hD0, L, L, 5'd0, 5'd0, 5'd0,
            L, H, H, 5'd6, 32'h66, 2'd1, 32'h0010_0000}, "rst_push");
    bus.pipe_we_i = H; bus.pipe_rd_i = 5'd6; bus.pipe_data_i = 32'h67;
    bus.mdu_valid_i = H; bus.mdu_rd_i = 5'd21; bus.mdu_data_i = 32'hD1;
    @(posedge clk); #1;
    check_regs("rst_pre", H, 5'd6, 32'h67, 2'd2, 32'h0010_0000);
    #2 rstn = 1'b0;
    #1;
    check("rst_async mdu_ready", 32'(bus.mdu_ready_o), 32'd0);
    check_regs("rst_async", L, 5'd0, 32'h0, 2'd0, 32'h0);
    @(negedge clk);
    bus.pipe_we_i = L; bus.pipe_rd_i = '0; bus.pipe_data_i = '0;
    bus.mdu_valid_i = L; bus.mdu_rd_i = '0; bus.mdu_data_i = '0;
    rstn = 1'b1;
    apply(idle(L, H, L, 5'd0, 32'h0, 2'd0, 32'h0), "rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
